bcd_seg_scan: RTL and testbench

- Sits directly downstream of the binary-to-BCD converter.
- Captures one 3-digit BCD value (hundreds 0-2, tens, units) on a load strobe.
- Drives a time-multiplexed 3-digit 7-segment display: one digit enable active at a time, rotating at a fixed scan rate.
- New values are applied only at frame boundaries, so a digit never shows a mix of old and new data (no tearing).

---
 rtl/bcd_disp_pkg.sv | 29 ++
 rtl/seg7_decode.sv | 26 ++
 rtl/bcd_seg_scan.sv | 156 +++++++++++++++
 tb/tb_bcd_seg_scan.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the 3-digit BCD 7-segment scanner.
// Segment constants are active-high, bit order {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    ST_UNITS = 2'd0,
    ST_TENS  = 2'd1,
    ST_HUNDS = 2'd2
  } scan_state_e;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [2:0] AN_NONE  = 3'b000;
  localparam logic [2:0] AN_UNITS = 3'b001;
  localparam logic [2:0] AN_TENS  = 3'b010;
  localparam logic [2:0] AN_HUNDS = 3'b100;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-high 7-segment pattern; non-decimal codes show a dash.
module seg7_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Time-multiplexed 3-digit 7-segment scanner with tear-free frame-boundary updates.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_seg_scan
  import bcd_disp_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [1:0] hunds,
  input  logic [3:0] tens,
  input  logic [3:0] units,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       pending
);

  localparam int              DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [6:0]      SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  scan_state_e      state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       holdHunds_q, holdHunds_d, dispHunds_q, dispHunds_d;
  logic [3:0]       holdTens_q, holdTens_d, dispTens_q, dispTens_d;
  logic [3:0]       holdUnits_q, holdUnits_d, dispUnits_q, dispUnits_d;
  logic             pending_q, pending_d;
  logic [6:0]       seg_q, seg_d;
  logic [2:0]       an_q, an_d;
  logic             boundary;
  logic [3:0]       digitSel;
  logic [6:0]       digitSeg;
  logic             blank;

  assign boundary = (state_q == ST_HUNDS) && (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q + DIV_W'(1);
    if (div_q == DIV_LAST) begin
      div_d = '0;
      unique case (state_q)
        ST_UNITS: state_d = ST_TENS;
        ST_TENS:  state_d = ST_HUNDS;
        ST_HUNDS: state_d = ST_UNITS;
        default:  state_d = ST_UNITS;
      endcase
    end
  end

  // A load on the boundary cycle goes straight to the display so it is never left pending.
  always_comb begin
    holdHunds_d = holdHunds_q;
    holdTens_d  = holdTens_q;
    holdUnits_d = holdUnits_q;
    dispHunds_d = dispHunds_q;
    dispTens_d  = dispTens_q;
    dispUnits_d = dispUnits_q;
    pending_d   = pending_q;
    if (boundary) begin
      pending_d = 1'b0;
      if (load) begin
        dispHunds_d = hunds;
        dispTens_d  = tens;
        dispUnits_d = units;
      end else if (pending_q) begin
        dispHunds_d = holdHunds_q;
        dispTens_d  = holdTens_q;
        dispUnits_d = holdUnits_q;
      end
    end else if (load) begin
      holdHunds_d = hunds;
      holdTens_d  = tens;
      holdUnits_d = units;
      pending_d   = 1'b1;
    end
  end

  // Outputs are built from next-state values so an/seg follow the state register exactly.
  always_comb begin
    an_d     = AN_UNITS;
    digitSel = dispUnits_d;
    blank    = 1'b0;
    unique case (state_d)
      ST_UNITS: begin
        an_d     = AN_UNITS;
        digitSel = dispUnits_d;
      end
      ST_TENS: begin
        an_d     = AN_TENS;
        digitSel = dispTens_d;
`ifdef LEADING_ZERO_BLANK_EN
        blank    = (dispHunds_d == 2'd0) && (dispTens_d == 4'd0);
`endif
      end
      ST_HUNDS: begin
        an_d     = AN_HUNDS;
        digitSel = (dispHunds_d == 2'd3) ? 4'hF : {2'b00, dispHunds_d};
`ifdef LEADING_ZERO_BLANK_EN
        blank    = (dispHunds_d == 2'd0);
`endif
      end
      default: begin
        an_d     = AN_UNITS;
        digitSel = dispUnits_d;
      end
    endcase
  end

  seg7_decode u_decode (
    .digit_i(digitSel),
    .seg_o  (digitSeg)
  );

  always_comb begin
    seg_d = blank ? SEG_BLANK : digitSeg;
    if (SEG_ACTIVE_LOW) begin
      seg_d = ~seg_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_UNITS;
      div_q       <= '0;
      holdHunds_q <= '0;
      holdTens_q  <= '0;
      holdUnits_q <= '0;
      dispHunds_q <= '0;
      dispTens_q  <= '0;
      dispUnits_q <= '0;
      pending_q   <= 1'b0;
      an_q        <= AN_NONE;
      seg_q       <= SEG_OFF;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      holdHunds_q <= holdHunds_d;
      holdTens_q  <= holdTens_d;
      holdUnits_q <= holdUnits_d;
      dispHunds_q <= dispHunds_d;
      dispTens_q  <= dispTens_d;
      dispUnits_q <= dispUnits_d;
      pending_q   <= pending_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign seg     = seg_q;
  assign an      = an_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Scoreboard bench for bcd_seg_scan: a frame-position reference model queues the expected
// an/seg/pending for every clock edge, and a monitor compares them after each edge.
module tb_bcd_seg_scan;

  localparam int SD    = 4;
  localparam bit SAL   = 1'b1;
  localparam int FRAME = 3 * SD;

  typedef struct packed {
    logic [2:0] an;
    logic [6:0] seg;
    logic       pending;
  } expT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [1:0] hunds = '0;
  logic [3:0] tens = '0;
  logic [3:0] units = '0;
  logic [6:0] seg;
  logic [2:0] an;
  logic       pending;

  expT expQ[$];
  int  total = 0;
  int  bad = 0;
  bit  stimDone = 1'b0;

  // Reference model: position within the frame plus display/hold digit values.
  int  mPos = 0;
  int  mDisp[3];
  int  mHold[3];
  bit  mPend = 1'b0;

  bcd_seg_scan #(.SCAN_DIV(SD), .SEG_ACTIVE_LOW(SAL)) dut (
    .clk(clk), .rst(rst), .load(load), .hunds(hunds), .tens(tens), .units(units),
    .seg(seg), .an(an), .pending(pending)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] patOf(int v);
    case (v)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  function automatic logic [6:0] modelSeg(int digit);
    logic [6:0] raw;
    int v;
    bit blankIt;
    blankIt = 1'b0;
    if (digit == 2) v = (mDisp[2] > 2) ? 10 : mDisp[2];
    else            v = mDisp[digit];
`ifdef LEADING_ZERO_BLANK_EN
    if (digit == 2 && mDisp[2] == 0) blankIt = 1'b1;
    if (digit == 1 && mDisp[2] == 0 && mDisp[1] == 0) blankIt = 1'b1;
`endif
    raw = blankIt ? 7'h00 : patOf(v);
    return SAL ? ~raw : raw;
  endfunction

  // Drive one cycle of inputs, advance the model across the coming edge, queue the expectation.
  task automatic applyStimulus(input bit r, input bit l, input int h, input int t, input int u);
    expT e;
    @(negedge clk);
    rst   = r;
    load  = l;
    hunds = 2'(h);
    tens  = 4'(t);
    units = 4'(u);
    if (r) begin
      mPos = 0;
      for (int i = 0; i < 3; i++) begin
        mDisp[i] = 0;
        mHold[i] = 0;
      end
      mPend     = 1'b0;
      e.an      = 3'b000;
      e.seg     = SAL ? 7'h7F : 7'h00;
      e.pending = 1'b0;
    end else begin
      if (mPos == FRAME - 1) begin
        if (l) begin
          mDisp[0] = u; mDisp[1] = t; mDisp[2] = h;
        end else if (mPend) begin
          mDisp = mHold;
        end
        mPend = 1'b0;
      end else if (l) begin
        mHold[0] = u; mHold[1] = t; mHold[2] = h;
        mPend = 1'b1;
      end
      mPos      = (mPos + 1) % FRAME;
      e.an      = 3'(1 << (mPos / SD));
      e.seg     = modelSeg(mPos / SD);
      e.pending = mPend;
    end
    expQ.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
  endtask

  // Idle until the model's current cycle is at the requested frame position.
  task automatic idleUntil(input int pos);
    for (int i = 0; i < 2 * FRAME && mPos != pos; i++) applyStimulus(0, 0, 0, 0, 0);
  endtask

  task automatic checkOutput(input expT e);
    total++;
    if (an !== e.an || seg !== e.seg || pending !== e.pending) begin
      bad++;
      $display("[TB] FAIL scan t=%0t got an=%b seg=%h pend=%b required an=%b seg=%h pend=%b",
               $time, an, seg, pending, e.an, e.seg, e.pending);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int h, t, u;
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0);
    idle(FRAME + 2);

    idleUntil(5);
    applyStimulus(0, 1, 2, 5, 5);
    idle(2 * FRAME);

    idleUntil(1);
    applyStimulus(0, 1, 1, 2, 3);
    idle(3);
    applyStimulus(0, 1, 0, 4, 7);
    idle(2 * FRAME);

    idleUntil(FRAME - 1);
    applyStimulus(0, 1, 1, 0, 0);
    idle(FRAME);

    idleUntil(2);
    applyStimulus(0, 1, 0, 0, 7);
    idle(2 * FRAME);

    idleUntil(3);
    applyStimulus(0, 1, 3, 12, 9);
    idle(2);
    applyStimulus(1, 0, 0, 0, 0);
    idle(FRAME + 2);

    for (int k = 0; k < 400; k++) begin
      h = $urandom_range(3, 0);
      t = ($urandom_range(7, 0) == 0) ? $urandom_range(15, 10) : $urandom_range(9, 0);
      u = ($urandom_range(7, 0) == 0) ? $urandom_range(15, 10) : $urandom_range(9, 0);
      if ($urandom_range(4, 0) == 0) begin
        h = 0;
        if ($urandom_range(1, 0) == 0) t = 0;
      end
      applyStimulus($urandom_range(63, 0) == 0, $urandom_range(5, 0) == 0, h, t, u);
    end
    idle(2);

    @(negedge clk);
    @(negedge clk);
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain got=%0d required=0", expQ.size());
    end
    stimDone = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
